// File: rtl/noc_link_tx.sv
// Credit-based NoC link transmitter: drains a show-ahead flit FIFO onto a
// registered link, tracks downstream credits, and keeps packets atomic against pause.
module noc_link_tx #(
    parameter int FLIT_SIZE     = 86,
    parameter int EOP_BIT       = 85,
    parameter int CREDITS       = 4,
    parameter int CREDIT_SIZE   = 3,
    parameter int FLIT_CNT_SIZE = 16
) (
    input  logic                     clk_i,
    input  logic                     rstq_i,
    input  logic                     fifo_empty_i,
    input  logic [FLIT_SIZE-1:0]     fifo_data_i,
    output logic                     fifo_rdreq_o,
    input  logic                     pause_i,
    input  logic                     credit_i,
    output logic                     link_valid_o,
    output logic [FLIT_SIZE-1:0]     link_data_o,
    output logic [CREDIT_SIZE-1:0]   credit_cnt_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [FLIT_CNT_SIZE-1:0] flit_cnt_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;
    localparam logic [CREDIT_SIZE-1:0] CREDIT_MAX = CREDIT_SIZE'(CREDITS);

    logic [0:0]               state_q;
    logic [CREDIT_SIZE-1:0]   credit_q;
    logic [FLIT_CNT_SIZE-1:0] flit_cnt_q;
    logic                     send;

    // Pause only blocks the start of a packet; credit_i never feeds this path.
    always_comb begin
        send = rstq_i && !fifo_empty_i && (credit_q != '0)
               && !(state_q == ST_IDLE && pause_i);
    end

    assign fifo_rdreq_o = send;
    assign credit_cnt_o = credit_q;
    assign flit_cnt_o   = flit_cnt_q;
    assign busy_o       = (state_q == ST_BURST);

    always_ff @(posedge clk_i) begin
        if (!rstq_i) begin
            state_q      <= ST_IDLE;
            link_valid_o <= 1'b0;
            link_data_o  <= '0;
            credit_q     <= CREDIT_MAX;
            flit_cnt_q   <= '0;
            err_o        <= 1'b0;
        end else begin
            link_valid_o <= send;
            if (send) begin
                link_data_o <= fifo_data_i;
                flit_cnt_q  <= flit_cnt_q + FLIT_CNT_SIZE'(1);
                state_q     <= fifo_data_i[EOP_BIT] ? ST_IDLE : ST_BURST;
            end

            // A return with a full counter and no spend is an overflow: saturate and flag.
            if (credit_i && !send && credit_q == CREDIT_MAX) begin
                err_o <= 1'b1;
            end else begin
                credit_q <= credit_q - CREDIT_SIZE'(send) + CREDIT_SIZE'(credit_i);
            end
        end
    end

endmodule

// File: tb/tb_noc_link_tx.sv
// Directed table-driven bench for noc_link_tx plus hand-written multi-cycle sequences.
module tb_noc_link_tx;

    localparam int FS = 86;

    logic          clk_i = 1'b0;
    logic          rstq_i;
    logic          fifo_empty_i;
    logic [FS-1:0] fifo_data_i;
    logic          fifo_rdreq_o;
    logic          pause_i;
    logic          credit_i;
    logic          link_valid_o;
    logic [FS-1:0] link_data_o;
    logic [2:0]    credit_cnt_o;
    logic          busy_o;
    logic          err_o;
    logic [15:0]   flit_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    noc_link_tx #(
        .FLIT_SIZE     (86),
        .EOP_BIT       (85),
        .CREDITS       (4),
        .CREDIT_SIZE   (3),
        .FLIT_CNT_SIZE (16)
    ) dut (
        .clk_i        (clk_i),
        .rstq_i       (rstq_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rdreq_o (fifo_rdreq_o),
        .pause_i      (pause_i),
        .credit_i     (credit_i),
        .link_valid_o (link_valid_o),
        .link_data_o  (link_data_o),
        .credit_cnt_o (credit_cnt_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .flit_cnt_o   (flit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        empty;
        logic        eop;
        logic        pause;
        logic        cr;
        logic        e_rd;
        logic        e_valid;
        logic        e_busy;
        logic [2:0]  e_cred;
        logic        e_err;
        logic [15:0] e_flit;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [FS-1:0] mkflit(input logic eop, input int idx);
        logic [63:0] lo;
        lo = 64'hA5A5_0000_0000_0000 | 64'(idx);
        return {eop, 21'(idx), lo};
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rstq_i       = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_data_i  = '0;
        pause_i      = 1'b0;
        credit_i     = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rstq_i = 1'b1;
    endtask

    logic [FS-1:0] exp_data;
    int            pops;
    logic          last_send;

    initial begin
        rstq_i       = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_data_i  = '0;
        pause_i      = 1'b0;
        credit_i     = 1'b0;

        //            empty eop pause cr  rd  val busy cred err flit
        vq.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,3'd3,1'b0,16'd1});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1,3'd3,1'b0,16'd2});
        vq.push_back('{1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,3'd3,1'b0,16'd3});
        vq.push_back('{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,3'd4,1'b0,16'd3});
        vq.push_back('{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,3'd4,1'b0,16'd3});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,3'd3,1'b0,16'd4});
        vq.push_back('{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,3'd2,1'b0,16'd5});
        vq.push_back('{1'b0,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b1,3'd2,1'b0,16'd6});
        vq.push_back('{1'b0,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,3'd1,1'b0,16'd7});
        vq.push_back('{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,3'd2,1'b0,16'd7});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,3'd1,1'b0,16'd8});
        vq.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,3'd0,1'b0,16'd9});
        vq.push_back('{1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,3'd1,1'b0,16'd9});
        vq.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,3'd0,1'b0,16'd10});
        vq.push_back('{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,3'd1,1'b0,16'd10});
        vq.push_back('{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,3'd2,1'b0,16'd10});
        vq.push_back('{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,3'd3,1'b0,16'd10});
        vq.push_back('{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,3'd4,1'b0,16'd10});
        vq.push_back('{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,3'd4,1'b1,16'd10});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,3'd4,1'b1,16'd10});
        vq.push_back('{1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,3'd4,1'b1,16'd11});

        // Reset state
        do_reset();
        chk("rst_valid", 128'(link_valid_o), 128'(0));
        chk("rst_data",  128'(link_data_o),  128'(0));
        chk("rst_cred",  128'(credit_cnt_o), 128'(4));
        chk("rst_flit",  128'(flit_cnt_o),   128'(0));
        chk("rst_err",   128'(err_o),        128'(0));
        chk("rst_busy",  128'(busy_o),       128'(0));

        exp_data = '0;
        foreach (vq[i]) begin
            @(negedge clk_i);
            fifo_empty_i = vq[i].empty;
            fifo_data_i  = mkflit(vq[i].eop, i + 1);
            pause_i      = vq[i].pause;
            credit_i     = vq[i].cr;
            #1;
            chk($sformatf("v%0d_rdreq", i), 128'(fifo_rdreq_o), 128'(vq[i].e_rd));
            if (vq[i].e_valid) exp_data = fifo_data_i;
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_valid", i), 128'(link_valid_o), 128'(vq[i].e_valid));
            chk($sformatf("v%0d_data", i),  128'(link_data_o),  128'(exp_data));
            chk($sformatf("v%0d_busy", i),  128'(busy_o),       128'(vq[i].e_busy));
            chk($sformatf("v%0d_cred", i),  128'(credit_cnt_o), 128'(vq[i].e_cred));
            chk($sformatf("v%0d_err", i),   128'(err_o),        128'(vq[i].e_err));
            chk($sformatf("v%0d_flit", i),  128'(flit_cnt_o),   128'(vq[i].e_flit));
        end

        // Credit loop: six single-flit packets waiting, no returns -> exactly four pops
        do_reset();
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            fifo_empty_i = 1'b0;
            fifo_data_i  = mkflit(1'b1, 100 + pops);
            credit_i     = 1'b0;
            #1;
            if (fifo_rdreq_o) pops++;
        end
        chk("loop_pops", 128'(pops), 128'(4));
        chk("loop_cred", 128'(credit_cnt_o), 128'(0));
        @(negedge clk_i);
        credit_i = 1'b1;
        #1;
        chk("loop_credit_same_cycle_rd", 128'(fifo_rdreq_o), 128'(0));
        @(negedge clk_i);
        credit_i = 1'b0;
        #1;
        chk("loop_5th_pop_next_cycle", 128'(fifo_rdreq_o), 128'(1));
        chk("loop_err", 128'(err_o), 128'(0));

        // Reset mid-burst with one credit left and err already set
        do_reset();
        @(negedge clk_i);
        credit_i = 1'b1;
        @(negedge clk_i);
        credit_i = 1'b0;
        chk("mid_err_set", 128'(err_o), 128'(1));
        for (int k = 0; k < 3; k++) begin
            fifo_empty_i = 1'b0;
            fifo_data_i  = mkflit(1'b0, 200 + k);
            @(negedge clk_i);
        end
        chk("mid_busy", 128'(busy_o), 128'(1));
        chk("mid_cred", 128'(credit_cnt_o), 128'(1));
        rstq_i = 1'b0;
        #1;
        chk("mid_rdreq_in_reset", 128'(fifo_rdreq_o), 128'(0));
        @(posedge clk_i);
        #1;
        chk("mid_rst_busy",  128'(busy_o),       128'(0));
        chk("mid_rst_cred",  128'(credit_cnt_o), 128'(4));
        chk("mid_rst_valid", 128'(link_valid_o), 128'(0));
        chk("mid_rst_flit",  128'(flit_cnt_o),   128'(0));
        chk("mid_rst_err",   128'(err_o),        128'(0));
        chk("mid_rst_data",  128'(link_data_o),  128'(0));

        // Wrap: 65537 flits with credits returned one cycle after each send
        do_reset();
        pops      = 0;
        last_send = 1'b0;
        fifo_data_i = mkflit(1'b1, 300);
        for (int c = 0; c < 70000 && pops < 65537; c++) begin
            @(negedge clk_i);
            fifo_empty_i = 1'b0;
            credit_i     = last_send;
            #1;
            last_send = fifo_rdreq_o;
            if (fifo_rdreq_o) pops++;
        end
        chk("wrap_pops_reached", 128'(pops), 128'(65537));
        @(posedge clk_i);
        #1;
        fifo_empty_i = 1'b1;
        credit_i     = 1'b0;
        @(negedge clk_i);
        chk("wrap_flit_cnt", 128'(flit_cnt_o), 128'(1));
        chk("wrap_err", 128'(err_o), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
